fp_mult_result_q: RTL and testbench

//  Downstream result stage for the combinational FP multiplier: captures {z, status, tag} each

---
 rtl/fp_mult_pkg.sv | 25 ++
 rtl/fp_res_fifo.sv | 65 ++++++
 rtl/fp_mult_result_q.sv | 101 ++++++++++
 tb/tb_fp_mult_result_q.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// Shared definitions for the FP multiplier and its downstream result stage.
package fp_mult_pkg;

    localparam int unsigned STATUS_W   = 8;
    localparam int unsigned FLAG_W     = 6;

    localparam int unsigned ST_ZERO    = 0;
    localparam int unsigned ST_INF     = 1;
    localparam int unsigned ST_NAN     = 2;
    localparam int unsigned ST_TINY    = 3;
    localparam int unsigned ST_HUGE    = 4;
    localparam int unsigned ST_INEXACT = 5;

    // One buffered multiplier result; the tag is appended by the user.
    typedef struct packed {
        logic [31:0]       z;
        logic [FLAG_W-1:0] flags;
    } fp_res_t;

    // The top two status bits carry no information and are dropped on entry.
    function automatic logic [FLAG_W-1:0] status_to_flags(input logic [STATUS_W-1:0] status);
        return status[FLAG_W-1:0];
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Small synchronous FIFO: DEPTH entries, wrapping pointers, occupancy 0..DEPTH.
module fp_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr, rd;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign wr = wr_en_i & ~full_o;
    assign rd = rd_en_i & ~empty_o;

    // Next pointer and occupancy values from this cycle's write/read.
    always_comb begin
        wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({wr, rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any buffered entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; contents are only observed through a valid head so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fp_mult_result_q.sv
// Result stage behind the FP multiplier: FIFO buffering, sticky exception flags, accept counter.
module fp_mult_result_q
    import fp_mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_z,
    input  logic [STATUS_W-1:0]    in_status,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_z,
    output logic [STATUS_W-1:0]    out_status,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   flags_clr,
    output logic [FLAG_W-1:0]      flags_acc,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       acc_count
);

    typedef struct packed {
        fp_res_t          res;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t            wr_entry, head;
    logic              full, empty;
    logic              push, pop;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              unused_status_hi;

    assign unused_status_hi = ^in_status[STATUS_W-1:FLAG_W];

    // Acceptance depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready  = ~full & ~rst;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wr_entry.res.z     = in_z;
    assign wr_entry.res.flags = status_to_flags(in_status);
    assign wr_entry.tag       = in_tag;

    fp_res_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .level_o   (level),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Head fields are forced to zero whenever nothing valid is presented.
    always_comb begin
        out_z      = '0;
        out_status = '0;
        out_tag    = '0;
        if (out_valid) begin
            out_z      = head.res.z;
            out_status = {{(STATUS_W-FLAG_W){1'b0}}, head.res.flags};
            out_tag    = head.tag;
        end
    end

    // Sticky flags: a clear wins over history but not over the entry accepted in the same cycle.
    always_comb begin
        flags_d = flags_clr ? '0 : flags_q;
        if (push) begin
            flags_d = flags_d | wr_entry.res.flags;
        end
        cnt_d = push ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Flag and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flags_acc = flags_q;
    assign acc_count = cnt_q;

endmodule

// File: tb/tb_fp_mult_result_q.sv
// Randomized and directed bench for fp_mult_result_q against a queue-based reference model.
module tb_fp_mult_result_q;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flags_clr;
    logic [31:0] in_z;
    logic [7:0]  in_status;
    logic [3:0]  in_tag;

    logic        in_ready, out_valid;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic [3:0]  out_tag;
    logic [5:0]  flags_acc;
    logic [2:0]  level;
    logic [15:0] acc_count;

    logic        in_ready4, out_valid4;
    logic [31:0] out_z4;
    logic [7:0]  out_status4;
    logic [3:0]  out_tag4;
    logic [5:0]  flags_acc4;
    logic [2:0]  level4;
    logic [3:0]  acc_count4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    fp_mult_result_q #(.DEPTH(DEPTH), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_status(in_status), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_status(out_status), .out_tag(out_tag),
        .flags_clr(flags_clr), .flags_acc(flags_acc),
        .level(level), .acc_count(acc_count)
    );

    // Narrow-counter build sharing the same stimulus, used for wrap behaviour.
    fp_mult_result_q #(.DEPTH(DEPTH), .TAG_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_z(in_z), .in_status(in_status), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_z(out_z4), .out_status(out_status4), .out_tag(out_tag4),
        .flags_clr(flags_clr), .flags_acc(flags_acc4),
        .level(level4), .acc_count(acc_count4)
    );

    // Reference model: a queue of results, sticky flag word, unbounded accept count.
    typedef struct {
        logic [31:0] z;
        logic [5:0]  f;
        logic [3:0]  t;
    } mref_t;

    mref_t       mq[$];
    logic [5:0]  m_flags = '0;
    int unsigned m_count = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_state();
        logic        ev;
        logic [31:0] ez;
        logic [7:0]  es;
        logic [3:0]  et;
        ev = (mq.size() != 0);
        ez = ev ? mq[0].z : 32'h0;
        es = ev ? {2'b00, mq[0].f} : 8'h00;
        et = ev ? mq[0].t : 4'h0;
        chk_eq("in_ready",   in_ready,   (!rst && mq.size() < DEPTH));
        chk_eq("out_valid",  out_valid,  ev);
        chk_eq("out_z",      out_z,      ez);
        chk_eq("out_status", out_status, es);
        chk_eq("out_tag",    out_tag,    et);
        chk_eq("level",      level,      mq.size());
        chk_eq("flags_acc",  flags_acc,  m_flags);
        chk_eq("acc_count",  acc_count,  m_count % 65536);
        chk_eq("acc_count4", acc_count4, m_count % 16);
        chk_eq("level4",     level4,     mq.size());
    endtask

    // Called at a falling edge: apply inputs, check the presented state, advance the model
    // across the coming rising edge, and return at the next falling edge.
    task automatic drive_cycle(input bit r, input bit iv, input logic [31:0] z, input logic [7:0] st,
                               input logic [3:0] tg, input bit ordy, input bit clr);
        bit    push, pop;
        mref_t e;
        rst = r; in_valid = iv; in_z = z; in_status = st; in_tag = tg;
        out_ready = ordy; flags_clr = clr;
        if (r) begin
            mq.delete();
            m_flags = '0;
            m_count = 0;
        end
        #1;
        check_state();
        if (!r) begin
            push = iv && (mq.size() < DEPTH);
            pop  = ordy && (mq.size() != 0);
            m_flags = (clr ? 6'h00 : m_flags) | (push ? st[5:0] : 6'h00);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.z = z; e.f = st[5:0]; e.t = tg;
                mq.push_back(e);
                m_count++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_cycle(1, 0, 32'h0, 8'h00, 4'h0, 0, 0);
        drive_cycle(1, 0, 32'h0, 8'h00, 4'h0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_z = '0; in_status = '0; in_tag = '0;
        out_ready = 0; flags_clr = 0;
        @(negedge clk);
        do_reset();

        // Reset mid-burst with three entries buffered.
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 32'h3f80_0000 + i, 8'h11, 4'(i), 0, 0);
        chk_eq("pre_rst_level", level, 3);
        drive_cycle(1, 1, 32'h1234_5678, 8'h3f, 4'hf, 1, 0);
        chk_eq("rst_level", level, 0);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_flags", flags_acc, 0);
        chk_eq("rst_count", acc_count, 0);
        chk_eq("rst_out_z", out_z, 0);
        chk_eq("rst_in_ready", in_ready, 0);
        drive_cycle(0, 0, 32'h0, 8'h00, 4'h0, 0, 0);
        chk_eq("post_rst_in_ready", in_ready, 1);

        // Single pass.
        drive_cycle(0, 1, 32'h4000_0000, 8'h00, 4'd5, 0, 0);
        chk_eq("sp_valid", out_valid, 1);
        chk_eq("sp_z", out_z, 32'h4000_0000);
        chk_eq("sp_tag", out_tag, 5);
        drive_cycle(0, 0, 32'h0, 8'h00, 4'h0, 1, 0);
        chk_eq("sp_empty", out_valid, 0);
        chk_eq("sp_count", acc_count, 1);

        // Fill, then a push attempt while full with a pop in the same cycle.
        for (int i = 0; i < 4; i++) drive_cycle(0, 1, 32'hc000_0000 + i, 8'h00, 4'(8 + i), 0, 0);
        chk_eq("full_level", level, 4);
        chk_eq("full_in_ready", in_ready, 0);
        drive_cycle(0, 0, 32'h0, 8'h00, 4'h0, 0, 0);
        chk_eq("stall_hold_z", out_z, 32'hc000_0000);
        drive_cycle(0, 1, 32'hdead_beef, 8'h00, 4'hf, 1, 0);
        chk_eq("full_pop_level", level, 3);
        chk_eq("full_pop_head", out_tag, 9);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 32'h0, 8'h00, 4'h0, 1, 0);

        // Sticky flags.
        do_reset();
        drive_cycle(0, 1, 32'h1, 8'h20, 4'h1, 1, 0);
        drive_cycle(0, 1, 32'h2, 8'h04, 4'h2, 1, 0);
        chk_eq("flags_or", flags_acc, 8'h24);
        drive_cycle(0, 1, 32'h3, 8'h02, 4'h3, 1, 1);
        chk_eq("flags_clr_push", flags_acc, 8'h02);
        drive_cycle(0, 1, 32'h4, 8'hc1, 4'h4, 1, 0);
        chk_eq("status_strip", out_status, 8'h01);
        chk_eq("flags_bit0", flags_acc, 8'h03);
        drive_cycle(0, 0, 32'h0, 8'h00, 4'h0, 1, 0);

        // Streaming, twenty results with tags 0..19.
        do_reset();
        for (int i = 0; i < 20; i++) drive_cycle(0, 1, 32'h4100_0000 + i, 8'h00, 4'(i), 1, 0);
        chk_eq("stream_level", level, 1);
        chk_eq("stream_count", acc_count, 20);
        chk_eq("stream_count4", acc_count4, 4);
        drive_cycle(0, 0, 32'h0, 8'h00, 4'h0, 1, 0);

        // Narrow counter wraps after 16 accepts.
        do_reset();
        for (int i = 0; i < 17; i++) drive_cycle(0, 1, 32'h0, 8'h00, 4'(i), 1, 0);
        chk_eq("wrap_count4", acc_count4, 1);

        // Randomized traffic with varying pressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            int unsigned pv, pr;
            pv = (i / 100) % 2 == 0 ? 70 : 35;
            pr = (i / 100) % 2 == 0 ? 35 : 80;
            drive_cycle(($urandom_range(0, 99) == 0),
                        ($urandom_range(0, 99) < pv),
                        $urandom(),
                        8'($urandom_range(0, 255)),
                        4'($urandom_range(0, 15)),
                        ($urandom_range(0, 99) < pr),
                        ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
